// File: rtl/if_fetch_ctrl_if.sv
// Fetch-stage bus: hazard/EX control inputs in, SRAM request and IF/ID
// select out. The master side is the fetch controller.
interface if_fetch_ctrl_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] pc;
  logic [1:0]  instr_sel;

  modport master (
    input  stall, redirect, redirect_pc,
    output im_req, im_addr, pc, instr_sel
  );

  modport slave (
    output stall, redirect, redirect_pc,
    input  im_req, im_addr, pc, instr_sel
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch control: owns the architectural PC, issues SRAM reads,
// and selects live data or NOP for the IF/ID register. Outputs are a
// combinational function of the registered state and the current
// stall/redirect, so the SRAM sees the new address in the same cycle.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  if_fetch_ctrl_if.master bus
);

  localparam logic [1:0] SEL_LIVE = 2'b00;
  localparam logic [1:0] SEL_NOP  = 2'b10;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_BOOT  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] pc_id;
  logic        flush_d;
  logic        flush_next;
  logic        req_next;
  logic [31:0] fetch_addr;
  logic [1:0]  sel_next;
  logic [31:0] target;

  // Redirect targets are forced to word alignment.
  assign target = bus.redirect_pc & ~32'd3;

  // State register; any low rst cycle returns everything to the reset image.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_RESET;
      pc_reg    <= RESET_PC;
      pc_id     <= RESET_PC;
      flush_d   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      pc_id     <= fetch_addr;  // tracks the PC that lands in ID next cycle
      flush_d   <= flush_next;
    end
  end

  // Next-state, fetch address and IF/ID select.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    flush_next = 1'b0;
    req_next   = 1'b0;
    fetch_addr = RESET_PC;
    sel_next   = SEL_NOP;
    case (state_reg)
      ST_RESET: begin
        state_next = ST_BOOT;
      end
      ST_BOOT: begin
        // SRAM output is not valid yet, so ID still gets a bubble.
        req_next   = 1'b1;
        fetch_addr = pc_reg;
        pc_next    = pc_reg + 32'd4;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        req_next = 1'b1;
        if (bus.redirect) begin
          // Redirect beats stall; this fetch is killed next cycle via flush_d.
          fetch_addr = pc_reg;
          pc_next    = target;
          flush_next = 1'b1;
        end else if (bus.stall) begin
          // Re-read the ID instruction so the SRAM output stays valid.
          fetch_addr = pc_id;
        end else begin
          fetch_addr = pc_reg;
          pc_next    = pc_reg + 32'd4;
        end
        sel_next = (bus.redirect || flush_d) ? SEL_NOP : SEL_LIVE;
      end
      default: begin
        state_next = ST_RESET;
      end
    endcase
  end

  assign bus.im_req    = req_next;
  assign bus.im_addr   = fetch_addr;
  assign bus.pc        = fetch_addr;
  assign bus.instr_sel = sel_next;

endmodule
